// File: rtl/spi_byte_queue_if.sv
// ---------------------------------------------------------------------------
// spi_byte_queue_if: CPU-side and SPI-engine-side signals of the byte queue. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface spi_byte_queue_if #(
  parameter int AW = 3
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_full;
  logic [AW:0]   tx_count;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rx_empty;
  logic [AW:0]   rx_count;
  logic          busy;
  logic          tx_ovf;
  logic          rx_ovf;
  logic          clr_ovf;
  logic [7:0]    spi_txdin;
  logic          spi_txgo;
  logic          spi_txrdy;
  logic [7:0]    spi_rxdout;

  modport master (
    output wr_en, wr_data, rd_en, clr_ovf, spi_txrdy, spi_rxdout,
    input  tx_full, tx_count, rd_data, rx_empty, rx_count, busy,
           tx_ovf, rx_ovf, spi_txdin, spi_txgo
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_ovf, spi_txrdy, spi_rxdout,
    output tx_full, tx_count, rd_data, rx_empty, rx_count, busy,
           tx_ovf, rx_ovf, spi_txdin, spi_txgo
  );
endinterface

`default_nettype wire

// File: rtl/spi_byte_queue.sv
// ---------------------------------------------------------------------------
// spi_byte_queue: TX/RX byte FIFOs with a sequencer feeding an SPI byte engine. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_byte_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  spi_byte_queue_if.slave   bus
);

  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] C_PINC = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_CAPTURE   = 3'd4
  } state_t;

  state_t          r_state;
  logic [7:0]      r_tx_mem [DEPTH];
  logic [7:0]      r_rx_mem [DEPTH];
  logic [AW-1:0]   r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic [AW:0]     r_tx_count, r_rx_count;
  logic            r_tx_ovf, r_rx_ovf, r_txgo;
  logic [7:0]      r_txdin;

  logic            w_tx_full, w_rx_full, w_rx_empty;
  logic            w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;

  // Fullness is taken from the registered count, so a LOAD pop never frees room for a same-cycle write.
  assign w_tx_full  = (r_tx_count == C_FULL);
  assign w_rx_full  = (r_rx_count == C_FULL);
  assign w_rx_empty = (r_rx_count == '0);
  assign w_tx_push  = bus.wr_en & ~w_tx_full;
  assign w_tx_pop   = (r_state == S_LOAD);
  assign w_rx_push  = (r_state == S_CAPTURE) & ~w_rx_full;
  assign w_rx_pop   = bus.rd_en & ~w_rx_empty;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus.wr_data;
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= bus.spi_rxdout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + C_PINC;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + C_PINC;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + C_PINC;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + C_PINC;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + C_ONE;
        2'b01:   r_tx_count <= r_tx_count - C_ONE;
        default: r_tx_count <= r_tx_count;
      endcase
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + C_ONE;
        2'b01:   r_rx_count <= r_rx_count - C_ONE;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // clr_ovf wins over any set arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else if (bus.clr_ovf) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (bus.wr_en & w_tx_full)               r_tx_ovf <= 1'b1;
      if ((r_state == S_CAPTURE) & w_rx_full)  r_rx_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_txgo  <= 1'b0;
      r_txdin <= 8'h00;
    end else begin
      r_txgo <= 1'b0;
      case (r_state)
        S_IDLE:      if ((r_tx_count != '0) && bus.spi_txrdy) r_state <= S_LOAD;
        S_LOAD: begin
          r_txdin <= r_tx_mem[r_tx_rptr];
          r_txgo  <= 1'b1;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: if (!bus.spi_txrdy) r_state <= S_WAIT_DONE;
        S_WAIT_DONE: if (bus.spi_txrdy)  r_state <= S_CAPTURE;
        S_CAPTURE:   r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_full   = w_tx_full;
  assign bus.tx_count  = r_tx_count;
  assign bus.rd_data   = r_rx_mem[r_rx_rptr];
  assign bus.rx_empty  = w_rx_empty;
  assign bus.rx_count  = r_rx_count;
  assign bus.busy      = (r_state != S_IDLE) | (r_tx_count != '0);
  assign bus.tx_ovf    = r_tx_ovf;
  assign bus.rx_ovf    = r_rx_ovf;
  assign bus.spi_txdin = r_txdin;
  assign bus.spi_txgo  = r_txgo;

endmodule

`default_nettype wire

// File: tb/tb_spi_byte_queue.sv
// ---------------------------------------------------------------------------
// tb_spi_byte_queue: queue-level model plus loopback SPI engine for spi_byte_queue. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_spi_byte_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_byte_queue_if #(.AW(AW)) bus ();
  spi_byte_queue #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int n_go    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: byte queues plus the sequencer step the transfer is currently in
  // (0 idle, 1 load, 2 awaiting engine busy, 3 awaiting engine done, 4 capture).
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];
  int         m_phase;
  logic       m_txgo;
  logic [7:0] m_txdin;
  logic       m_txovf, m_rxovf;
  logic       t_txfull, t_rxfull, t_rdy;

  // Engine: loops MOSI to MISO, ready drops the cycle after txgo for e_hold cycles.
  logic       e_stall = 1'b0;
  int         e_hold  = 3;
  int         e_cnt;
  logic       e_active;
  logic [7:0] e_byte;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_txq.delete();
      m_rxq.delete();
      m_phase = 0;
      m_txgo  = 1'b0;
      m_txdin = 8'h00;
      m_txovf = 1'b0;
      m_rxovf = 1'b0;
      e_active = 1'b0;
      e_cnt    = 0;
      e_byte   = 8'h00;
      bus.spi_txrdy  <= 1'b1;
      bus.spi_rxdout <= 8'h00;
    end else begin
      if (e_stall) bus.spi_txrdy <= 1'b0;
      else if (m_txgo) begin
        bus.spi_txrdy <= 1'b0;
        e_byte   = m_txdin;
        e_cnt    = e_hold;
        e_active = 1'b1;
      end else if (e_active) begin
        if (e_cnt <= 1) begin
          bus.spi_txrdy  <= 1'b1;
          bus.spi_rxdout <= e_byte;
          e_active = 1'b0;
        end else e_cnt--;
      end else bus.spi_txrdy <= 1'b1;

      t_txfull = (m_txq.size() == DEPTH);
      t_rxfull = (m_rxq.size() == DEPTH);
      t_rdy    = bus.spi_txrdy;
      if (bus.rd_en && m_rxq.size() > 0) void'(m_rxq.pop_front());
      m_txgo = 1'b0;
      case (m_phase)
        0: if (m_txq.size() != 0 && t_rdy) m_phase = 1;
        1: begin m_txdin = m_txq.pop_front(); m_txgo = 1'b1; m_phase = 2; end
        2: if (!t_rdy) m_phase = 3;
        3: if (t_rdy) m_phase = 4;
        default: begin
          if (!t_rxfull) m_rxq.push_back(bus.spi_rxdout);
          else m_rxovf = 1'b1;
          m_phase = 0;
        end
      endcase
      if (bus.wr_en) begin
        if (!t_txfull) m_txq.push_back(bus.wr_data);
        else m_txovf = 1'b1;
      end
      if (bus.clr_ovf) begin
        m_txovf = 1'b0;
        m_rxovf = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("tx_count", 32'(bus.tx_count), 32'(m_txq.size()));
      chk("tx_full",  32'(bus.tx_full),  32'(m_txq.size() == DEPTH));
      chk("rx_count", 32'(bus.rx_count), 32'(m_rxq.size()));
      chk("rx_empty", 32'(bus.rx_empty), 32'(m_rxq.size() == 0));
      if (m_rxq.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(m_rxq[0]));
      chk("busy",     32'(bus.busy),     32'(m_phase != 0 || m_txq.size() != 0));
      chk("tx_ovf",   32'(bus.tx_ovf),   32'(m_txovf));
      chk("rx_ovf",   32'(bus.rx_ovf),   32'(m_rxovf));
      chk("spi_txgo", 32'(bus.spi_txgo), 32'(m_txgo));
      chk("spi_txdin",32'(bus.spi_txdin),32'(m_txdin));
      if (bus.spi_txgo === 1'b1) n_go++;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic pop_byte(input string name, input logic [7:0] exp);
    chk(name, 32'(bus.rd_data), 32'(exp));
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait budget expired at %0t", name, $time);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_phase != 0 || m_txq.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) timeout("wait_idle");
  endtask

  task automatic wait_phase(input int p, input int budget);
    int k = 0;
    while (m_phase != p && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) timeout("wait_phase");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n0;

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;

    // reset values
    #23;
    chk("rst_tx_count", 32'(bus.tx_count), 32'd0);
    chk("rst_tx_full",  32'(bus.tx_full),  32'd0);
    chk("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_txgo",     32'(bus.spi_txgo), 32'd0);
    chk("rst_txdin",    32'(bus.spi_txdin),32'h00);
    chk("rst_ovf",      32'({bus.tx_ovf, bus.rx_ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single byte through loopback
    n0 = n_go;
    push_byte(8'hA5);
    wait_idle(100);
    chk("single_go",  32'(n_go - n0), 32'd1);
    chk("single_cnt", 32'(bus.rx_count), 32'd1);
    pop_byte("single_rd", 8'hA5);

    // burst of 8 with engine held busy, 9th write overflows
    e_stall = 1'b1;
    repeat (2) @(negedge clk);
    n0 = n_go;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    chk("burst_full",  32'(bus.tx_full),  32'd1);
    chk("burst_count", 32'(bus.tx_count), 32'd8);
    push_byte(8'h09);
    chk("burst_txovf", 32'(bus.tx_ovf),   32'd1);
    chk("burst_count9",32'(bus.tx_count), 32'd8);
    e_stall = 1'b0;
    wait_idle(400);
    chk("burst_go",    32'(n_go - n0),    32'd8);
    chk("burst_rxcnt", 32'(bus.rx_count), 32'd8);
    for (int i = 1; i <= 8; i++) pop_byte("burst_rd", 8'(i));
    pulse_clr();
    chk("burst_clr",   32'(bus.tx_ovf),   32'd0);

    // RX overflow: 9 transfers, no reads
    for (int i = 0; i < 9; i++) begin
      push_byte(8'h10 + 8'(i));
      wait_idle(100);
    end
    chk("rxovf_cnt",  32'(bus.rx_count), 32'd8);
    chk("rxovf_flag", 32'(bus.rx_ovf),   32'd1);
    for (int i = 0; i < 8; i++) pop_byte("rxovf_rd", 8'h10 + 8'(i));
    pulse_clr();
    chk("rxovf_clr",  32'(bus.rx_ovf),   32'd0);

    // simultaneous push/pop on both FIFOs
    push_byte(8'h21); wait_idle(100);
    push_byte(8'h22); wait_idle(100);
    e_stall = 1'b1;
    repeat (2) @(negedge clk);
    push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
    e_stall = 1'b0;
    wait_phase(1, 50);
    chk("sim_pre_tx", 32'(bus.tx_count), 32'd3);
    push_byte(8'h34);
    chk("sim_tx_cnt", 32'(bus.tx_count), 32'd3);
    wait_phase(4, 100);
    chk("sim_pre_rx", 32'(bus.rx_count), 32'd2);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("sim_rx_cnt", 32'(bus.rx_count), 32'd2);
    wait_idle(400);
    chk("sim_rx_end", 32'(bus.rx_count), 32'd5);
    pop_byte("sim_rd", 8'h22);
    pop_byte("sim_rd", 8'h31);
    pop_byte("sim_rd", 8'h32);
    pop_byte("sim_rd", 8'h33);
    pop_byte("sim_rd", 8'h34);

    // slow engine: ready held low 20 cycles
    e_hold = 20;
    n0 = n_go;
    push_byte(8'h5C);
    wait_phase(3, 50);
    repeat (15) @(negedge clk);
    chk("hs_waiting", 32'(bus.busy),     32'd1);
    chk("hs_no_cap",  32'(bus.rx_count), 32'd0);
    chk("hs_one_go",  32'(n_go - n0),    32'd1);
    wait_idle(100);
    chk("hs_go_end",  32'(n_go - n0),    32'd1);
    pop_byte("hs_rd", 8'h5C);
    e_hold = 3;

    // async reset in the middle of LOAD
    push_byte(8'h66);
    wait_idle(100);
    push_byte(8'h77);
    push_byte(8'h78);
    wait_phase(1, 50);
    #2 rst = 1'b1;
    #1;
    chk("arst_txgo",  32'(bus.spi_txgo), 32'd0);
    chk("arst_empty", 32'(bus.rx_empty), 32'd1);
    chk("arst_txcnt", 32'(bus.tx_count), 32'd0);
    chk("arst_busy",  32'(bus.busy),     32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    push_byte(8'h99);
    wait_idle(100);
    pop_byte("post_rst_rd", 8'h99);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
